// File: rtl/bpa_pkg.sv
// Shared types and constants for the back-prop accumulator.
// Saturation limits are consumed by bpa_sat_adder when BPA_SATURATE_EN is defined.
package bpa_pkg;
    localparam int BPC_W = 32;
    localparam int BP_W  = 64;

    typedef enum logic [1:0] {BPA_IDLE, BPA_ACCUM, BPA_DONE} bpa_state_t;
    typedef logic signed [BP_W-1:0] bp_t;

    localparam bp_t SAT_POS = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam bp_t SAT_NEG = 64'h8000_0000_0000_0000;

    function automatic bp_t sext_bpc(input logic [BPC_W-1:0] v);
        return bp_t'({{(BP_W-BPC_W){v[BPC_W-1]}}, v});
    endfunction
endpackage

// File: rtl/bpa_if.sv
// Handshake bundle between the bpc producers, the accumulator and the back-propagator.
interface bpa_if #(
    parameter int N_FANOUT = 4,
    parameter int CNT_W    = $clog2(N_FANOUT+1)
);
    logic                          bpa_start;
    logic                          bpa_in_valid;
    logic                          bpa_in_ready;
    logic [bpa_pkg::BPC_W-1:0]     bpa_in_bpc;
    logic                          bpa_out_valid;
    logic                          bpa_out_ready;
    logic [bpa_pkg::BP_W-1:0]      bpa_out_bp;
    logic [CNT_W-1:0]              bpa_out_count;
    logic                          bpa_overflow;
    logic                          bpa_busy;

    modport slave (
        input  bpa_start, bpa_in_valid, bpa_in_bpc, bpa_out_ready,
        output bpa_in_ready, bpa_out_valid, bpa_out_bp, bpa_out_count, bpa_overflow, bpa_busy
    );
    modport master (
        output bpa_start, bpa_in_valid, bpa_in_bpc, bpa_out_ready,
        input  bpa_in_ready, bpa_out_valid, bpa_out_bp, bpa_out_count, bpa_overflow, bpa_busy
    );
endinterface

// File: rtl/bpa_sat_adder.sv
// 64-bit signed add with overflow detect; clamps to the signed limits when
// BPA_SATURATE_EN is defined, otherwise wraps two's-complement.
module bpa_sat_adder
    import bpa_pkg::*;
(
    input  bp_t  a,
    input  bp_t  b,
    output bp_t  sum,
    output logic ovf
);
    bp_t raw;

    always_comb begin
        raw = a + b;
        // same-sign operands whose result flips sign
        ovf = (a[BP_W-1] == b[BP_W-1]) && (raw[BP_W-1] != a[BP_W-1]);
`ifdef BPA_SATURATE_EN
        sum = ovf ? (a[BP_W-1] ? SAT_NEG : SAT_POS) : raw;
`else
        sum = raw;
`endif
    end
endmodule

// File: rtl/backprop_accumulator.sv
// Sums N_FANOUT signed bpc beats into one 64-bit bp result with valid/ready on both sides.
// Optional clamp on overflow: define BPA_SATURATE_EN.
module backprop_accumulator
    import bpa_pkg::*;
#(
    parameter int N_FANOUT = 4,
    parameter int CNT_W    = $clog2(N_FANOUT+1)
) (
    input  logic     bpa_clk,
    input  logic     bpa_rst_n,
    bpa_if.slave     bus
);
    bpa_state_t       state, nxt;
    bp_t              acc, add_sum;
    logic [CNT_W-1:0] count;
    logic             ovf_q, add_ovf, beat, last_beat;

    // ready/valid are pure decodes of the state register, so no valid->ready path
    assign beat      = bus.bpa_in_valid && (state == BPA_ACCUM);
    assign last_beat = beat && (count == CNT_W'(N_FANOUT-1));

    bpa_sat_adder u_add (
        .a   (acc),
        .b   (sext_bpc(bus.bpa_in_bpc)),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    always_comb begin
        nxt = state;
        case (state)
            BPA_IDLE:  if (bus.bpa_start)     nxt = BPA_ACCUM;
            BPA_ACCUM: if (last_beat)         nxt = BPA_DONE;
            BPA_DONE:  if (bus.bpa_out_ready) nxt = BPA_IDLE;
            default:                          nxt = BPA_IDLE;
        endcase
    end

    always_ff @(posedge bpa_clk or negedge bpa_rst_n) begin
        if (!bpa_rst_n) begin
            state <= BPA_IDLE;
            acc   <= '0;
            count <= '0;
            ovf_q <= 1'b0;
        end else begin
            state <= nxt;
            if (state == BPA_IDLE && bus.bpa_start) begin
                acc   <= '0;
                count <= '0;
                ovf_q <= 1'b0;
            end else if (beat) begin
                acc   <= add_sum;
                count <= count + CNT_W'(1);
                ovf_q <= ovf_q | add_ovf;
            end
        end
    end

    assign bus.bpa_in_ready  = (state == BPA_ACCUM);
    assign bus.bpa_out_valid = (state == BPA_DONE);
    assign bus.bpa_out_bp    = acc;
    assign bus.bpa_out_count = count;
    assign bus.bpa_overflow  = ovf_q;
    assign bus.bpa_busy      = (state != BPA_IDLE);
endmodule
